// File: rtl/ysyx_22040237_bus_pkg.sv
// Shared widths, FSM encoding and owner codes for the IFU/LSU memory arbiter.
package ysyx_22040237_bus_pkg;

  localparam int unsigned ADDR_W   = 32;
  localparam int unsigned DATA_W   = 64;
  localparam int unsigned STRB_W   = DATA_W / 8;
  localparam int unsigned STARVE_W = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2
  } arb_state_e;

  localparam logic OWNER_IFU = 1'b0;
  localparam logic OWNER_LSU = 1'b1;

endpackage

// File: rtl/ysyx_22040237_bus_timer.sv
// Response watchdog: clearable counter with a terminal-count flag at TIMEOUT_CYC-1.
module ysyx_22040237_bus_timer #(
  parameter int unsigned TIMEOUT_CYC = 255
) (
  input  logic clk,
  input  logic rst,
  input  logic i_clr,
  input  logic i_en,
  output logic o_tc_c
);

  generate
    if (TIMEOUT_CYC == 0) begin : g_off
      // Timeout disabled: no counter, flag never fires.
      logic w_unused;
      assign w_unused = &{1'b0, clk, rst, i_clr, i_en};
      assign o_tc_c   = 1'b0;
    end else begin : g_on
      localparam int unsigned CNT_W = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
      logic [CNT_W-1:0] r_cnt;

      // Count enabled cycles since the last clear.
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          r_cnt <= '0;
        end else if (i_clr) begin
          r_cnt <= '0;
        end else if (i_en) begin
          r_cnt <= r_cnt + CNT_W'(1);
        end
      end

      assign o_tc_c = (r_cnt == CNT_W'(TIMEOUT_CYC - 1));
    end
  endgenerate

endmodule

// File: rtl/ysyx_22040237_mem_arbiter.sv
// Single-outstanding memory arbiter between IFU and LSU; LSU priority with IFU starvation guard.
module ysyx_22040237_mem_arbiter
  import ysyx_22040237_bus_pkg::*;
#(
  parameter int unsigned ADDR_W      = ysyx_22040237_bus_pkg::ADDR_W,
  parameter int unsigned DATA_W      = ysyx_22040237_bus_pkg::DATA_W,
  parameter int unsigned STARVE_MAX  = 4,
  parameter int unsigned TIMEOUT_CYC = 255
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                ifu_req_valid,
  output logic                ifu_req_ready,
  input  logic [ADDR_W-1:0]   ifu_req_addr,
  output logic                ifu_rsp_valid,
  output logic [DATA_W-1:0]   ifu_rsp_data,
  output logic                ifu_rsp_err,
  input  logic                lsu_req_valid,
  output logic                lsu_req_ready,
  input  logic [ADDR_W-1:0]   lsu_req_addr,
  input  logic                lsu_req_wen,
  input  logic [DATA_W-1:0]   lsu_req_wdata,
  input  logic [DATA_W/8-1:0] lsu_req_wmask,
  output logic                lsu_rsp_valid,
  output logic [DATA_W-1:0]   lsu_rsp_data,
  output logic                lsu_rsp_err,
  output logic                mem_req_valid,
  input  logic                mem_req_ready,
  output logic [ADDR_W-1:0]   mem_req_addr,
  output logic                mem_req_wen,
  output logic [DATA_W-1:0]   mem_req_wdata,
  output logic [DATA_W/8-1:0] mem_req_wmask,
  input  logic                mem_rsp_valid,
  input  logic [DATA_W-1:0]   mem_rsp_data,
  input  logic                mem_rsp_err,
  output logic                owner
);

  arb_state_e          r_state;
  arb_state_e          w_next;
  logic [STARVE_W-1:0] r_starve;
  logic [ADDR_W-1:0]   r_addr;
  logic                r_wen;
  logic [DATA_W-1:0]   r_wdata;
  logic [DATA_W/8-1:0] r_wmask;
  logic                r_owner;
  logic                r_ifu_rsp_valid;
  logic [DATA_W-1:0]   r_ifu_rsp_data;
  logic                r_ifu_rsp_err;
  logic                r_lsu_rsp_valid;
  logic [DATA_W-1:0]   r_lsu_rsp_data;
  logic                r_lsu_rsp_err;

  logic w_ifu_starved;
  logic w_lsu_win;
  logic w_ifu_win;
  logic w_tmr_clr;
  logic w_tmr_en;
  logic w_tmr_tc;
  logic w_timeout;

  // IFU overrides LSU priority once it has lost STARVE_MAX arbitrations in a row.
  assign w_ifu_starved = ifu_req_valid && (r_starve == STARVE_W'(STARVE_MAX));
  assign w_lsu_win     = lsu_req_valid && !w_ifu_starved;
  assign w_ifu_win     = ifu_req_valid && !w_lsu_win;

  assign w_tmr_clr = (r_state == ISSUE) && mem_req_ready;
  assign w_tmr_en  = (r_state == WAIT) && !mem_rsp_valid;
  assign w_timeout = w_tmr_en && w_tmr_tc;

  ysyx_22040237_bus_timer #(
    .TIMEOUT_CYC(TIMEOUT_CYC)
  ) u_timer (
    .clk   (clk),
    .rst   (rst),
    .i_clr (w_tmr_clr),
    .i_en  (w_tmr_en),
    .o_tc_c(w_tmr_tc)
  );

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Next-state logic.
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (w_lsu_win || w_ifu_win) w_next = ISSUE;
      ISSUE:   if (mem_req_ready) w_next = WAIT;
      WAIT:    if (mem_rsp_valid || w_timeout) w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  // State-decoded outputs; readys are combinational grants, masked during reset.
  always_comb begin
    ifu_req_ready = 1'b0;
    lsu_req_ready = 1'b0;
    mem_req_valid = 1'b0;
    case (r_state)
      IDLE: begin
        ifu_req_ready = w_ifu_win && !rst;
        lsu_req_ready = w_lsu_win && !rst;
      end
      ISSUE:   mem_req_valid = 1'b1;
      default: ;
    endcase
  end

  // Request latch, starvation counter and response routing.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_starve        <= '0;
      r_addr          <= '0;
      r_wen           <= 1'b0;
      r_wdata         <= '0;
      r_wmask         <= '0;
      r_owner         <= OWNER_IFU;
      r_ifu_rsp_valid <= 1'b0;
      r_ifu_rsp_data  <= '0;
      r_ifu_rsp_err   <= 1'b0;
      r_lsu_rsp_valid <= 1'b0;
      r_lsu_rsp_data  <= '0;
      r_lsu_rsp_err   <= 1'b0;
    end else begin
      r_ifu_rsp_valid <= 1'b0;
      r_lsu_rsp_valid <= 1'b0;
      if (r_state == IDLE) begin
        if (w_lsu_win) begin
          r_addr  <= lsu_req_addr;
          r_wen   <= lsu_req_wen;
          r_wdata <= lsu_req_wdata;
          r_wmask <= lsu_req_wmask;
          r_owner <= OWNER_LSU;
          if (ifu_req_valid && (r_starve < STARVE_W'(STARVE_MAX))) begin
            r_starve <= r_starve + STARVE_W'(1);
          end
        end else if (w_ifu_win) begin
          r_addr   <= ifu_req_addr;
          r_wen    <= 1'b0;
          r_wdata  <= '0;
          r_wmask  <= '0;
          r_owner  <= OWNER_IFU;
          r_starve <= '0;
        end
      end
      if ((r_state == WAIT) && (mem_rsp_valid || w_timeout)) begin
        if (r_owner == OWNER_LSU) begin
          r_lsu_rsp_valid <= 1'b1;
          r_lsu_rsp_data  <= mem_rsp_valid ? mem_rsp_data : '0;
          r_lsu_rsp_err   <= mem_rsp_valid ? mem_rsp_err : 1'b1;
        end else begin
          r_ifu_rsp_valid <= 1'b1;
          r_ifu_rsp_data  <= mem_rsp_valid ? mem_rsp_data : '0;
          r_ifu_rsp_err   <= mem_rsp_valid ? mem_rsp_err : 1'b1;
        end
      end
    end
  end

  assign mem_req_addr  = r_addr;
  assign mem_req_wen   = r_wen;
  assign mem_req_wdata = r_wdata;
  assign mem_req_wmask = r_wmask;
  assign owner         = r_owner;
  assign ifu_rsp_valid = r_ifu_rsp_valid;
  assign ifu_rsp_data  = r_ifu_rsp_data;
  assign ifu_rsp_err   = r_ifu_rsp_err;
  assign lsu_rsp_valid = r_lsu_rsp_valid;
  assign lsu_rsp_data  = r_lsu_rsp_data;
  assign lsu_rsp_err   = r_lsu_rsp_err;

endmodule

// File: tb/tb_ysyx_22040237_mem_arbiter.sv
// Directed bench for the IFU/LSU memory arbiter (STARVE_MAX=4, TIMEOUT_CYC=8).
module tb_ysyx_22040237_mem_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        ifu_req_valid, ifu_req_ready;
  logic [31:0] ifu_req_addr;
  logic        ifu_rsp_valid, ifu_rsp_err;
  logic [63:0] ifu_rsp_data;
  logic        lsu_req_valid, lsu_req_ready, lsu_req_wen;
  logic [31:0] lsu_req_addr;
  logic [63:0] lsu_req_wdata;
  logic [7:0]  lsu_req_wmask;
  logic        lsu_rsp_valid, lsu_rsp_err;
  logic [63:0] lsu_rsp_data;
  logic        mem_req_valid, mem_req_ready, mem_req_wen;
  logic [31:0] mem_req_addr;
  logic [63:0] mem_req_wdata;
  logic [7:0]  mem_req_wmask;
  logic        mem_rsp_valid, mem_rsp_err;
  logic [63:0] mem_rsp_data;
  logic        owner;

  int   total = 0;
  int   bad   = 0;
  logic exp_l;

  ysyx_22040237_mem_arbiter #(
    .ADDR_W(32), .DATA_W(64), .STARVE_MAX(4), .TIMEOUT_CYC(8)
  ) dut (
    .clk(clk), .rst(rst),
    .ifu_req_valid(ifu_req_valid), .ifu_req_ready(ifu_req_ready), .ifu_req_addr(ifu_req_addr),
    .ifu_rsp_valid(ifu_rsp_valid), .ifu_rsp_data(ifu_rsp_data), .ifu_rsp_err(ifu_rsp_err),
    .lsu_req_valid(lsu_req_valid), .lsu_req_ready(lsu_req_ready), .lsu_req_addr(lsu_req_addr),
    .lsu_req_wen(lsu_req_wen), .lsu_req_wdata(lsu_req_wdata), .lsu_req_wmask(lsu_req_wmask),
    .lsu_rsp_valid(lsu_rsp_valid), .lsu_rsp_data(lsu_rsp_data), .lsu_rsp_err(lsu_rsp_err),
    .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready), .mem_req_addr(mem_req_addr),
    .mem_req_wen(mem_req_wen), .mem_req_wdata(mem_req_wdata), .mem_req_wmask(mem_req_wmask),
    .mem_rsp_valid(mem_rsp_valid), .mem_rsp_data(mem_rsp_data), .mem_rsp_err(mem_rsp_err),
    .owner(owner)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Move to just after the next rising edge (input drive point).
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Move to the falling edge of the current cycle (sample point).
  task automatic mid();
    @(negedge clk);
  endtask

  // Called in the ISSUE cycle with mem_req_ready=1: respond in WAIT, return in the rsp_valid cycle.
  task automatic serve(input logic [63:0] d, input logic e);
    tick();
    mem_rsp_valid = 1'b1;
    mem_rsp_data  = d;
    mem_rsp_err   = e;
    tick();
    mem_rsp_valid = 1'b0;
    mem_rsp_data  = '0;
    mem_rsp_err   = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    ifu_req_valid = 1'b0; ifu_req_addr = '0;
    lsu_req_valid = 1'b0; lsu_req_addr = '0; lsu_req_wen = 1'b0;
    lsu_req_wdata = '0;   lsu_req_wmask = '0;
    mem_req_ready = 1'b1; mem_rsp_valid = 1'b0; mem_rsp_data = '0; mem_rsp_err = 1'b0;
    #2;
    chk("rst_mem_valid", 64'(mem_req_valid), 64'd0);
    chk("rst_ifu_rsp",   64'(ifu_rsp_valid), 64'd0);
    chk("rst_lsu_rsp",   64'(lsu_rsp_valid), 64'd0);
    chk("rst_owner",     64'(owner), 64'd0);
    chk("rst_addr",      64'(mem_req_addr), 64'd0);
    tick(); rst = 1'b0;

    // 1: IFU-only read, zero-wait memory.
    tick(); ifu_req_valid = 1'b1; ifu_req_addr = 32'h8000_0000; mid();
    chk("t1_ifu_ready", 64'(ifu_req_ready), 64'd1);
    chk("t1_lsu_ready", 64'(lsu_req_ready), 64'd0);
    chk("t1_mem_valid_n", 64'(mem_req_valid), 64'd0);
    tick(); ifu_req_valid = 1'b0; mid();
    chk("t1_mem_valid", 64'(mem_req_valid), 64'd1);
    chk("t1_mem_addr",  64'(mem_req_addr), 64'h8000_0000);
    chk("t1_mem_wen",   64'(mem_req_wen), 64'd0);
    chk("t1_mem_wmask", 64'(mem_req_wmask), 64'd0);
    chk("t1_owner",     64'(owner), 64'd0);
    serve(64'h0000_0013_0000_0093, 1'b0); mid();
    chk("t1_ifu_rsp_valid", 64'(ifu_rsp_valid), 64'd1);
    chk("t1_ifu_rsp_data",  ifu_rsp_data, 64'h0000_0013_0000_0093);
    chk("t1_ifu_rsp_err",   64'(ifu_rsp_err), 64'd0);
    chk("t1_lsu_rsp_valid", 64'(lsu_rsp_valid), 64'd0);
    tick(); mid();
    chk("t1_ifu_rsp_pulse", 64'(ifu_rsp_valid), 64'd0);

    // 2: simultaneous requests, LSU store wins, IFU follows.
    tick();
    ifu_req_valid = 1'b1; ifu_req_addr = 32'h8000_0040;
    lsu_req_valid = 1'b1; lsu_req_addr = 32'h8000_1000; lsu_req_wen = 1'b1;
    lsu_req_wdata = 64'h1122_3344_5566_7788; lsu_req_wmask = 8'hFF;
    mid();
    chk("t2_lsu_ready", 64'(lsu_req_ready), 64'd1);
    chk("t2_ifu_ready", 64'(ifu_req_ready), 64'd0);
    tick(); lsu_req_valid = 1'b0; mid();
    chk("t2_mem_addr",  64'(mem_req_addr), 64'h8000_1000);
    chk("t2_mem_wen",   64'(mem_req_wen), 64'd1);
    chk("t2_mem_wdata", mem_req_wdata, 64'h1122_3344_5566_7788);
    chk("t2_mem_wmask", 64'(mem_req_wmask), 64'hFF);
    chk("t2_owner",     64'(owner), 64'd1);
    chk("t2_ifu_ready_issue", 64'(ifu_req_ready), 64'd0);
    serve(64'h0000_0000_0000_5A5A, 1'b0); mid();
    chk("t2_lsu_rsp_valid", 64'(lsu_rsp_valid), 64'd1);
    chk("t2_ifu_rsp_valid", 64'(ifu_rsp_valid), 64'd0);
    chk("t2_ifu_data_hold", ifu_rsp_data, 64'h0000_0013_0000_0093);
    chk("t2_ifu_ready_next", 64'(ifu_req_ready), 64'd1);
    tick(); ifu_req_valid = 1'b0; mid();
    chk("t2_ifu_addr",  64'(mem_req_addr), 64'h8000_0040);
    chk("t2_ifu_wen",   64'(mem_req_wen), 64'd0);
    chk("t2_ifu_wmask", 64'(mem_req_wmask), 64'd0);
    chk("t2_ifu_owner", 64'(owner), 64'd0);
    serve(64'h0000_0000_0000_1234, 1'b0); mid();
    chk("t2_ifu_rsp_data", ifu_rsp_data, 64'h0000_0000_0000_1234);

    // 3: both held valid; grants 1-4 to LSU, 5th to IFU, 6th back to LSU.
    tick();
    ifu_req_valid = 1'b1; ifu_req_addr = 32'h8000_0080;
    lsu_req_valid = 1'b1; lsu_req_addr = 32'h8000_3000; lsu_req_wen = 1'b0;
    lsu_req_wdata = '0; lsu_req_wmask = '0;
    mid();
    for (int g = 1; g <= 6; g++) begin
      exp_l = (g != 5);
      chk($sformatf("t3_lsu_ready_g%0d", g), 64'(lsu_req_ready), 64'(exp_l));
      chk($sformatf("t3_ifu_ready_g%0d", g), 64'(ifu_req_ready), 64'(!exp_l));
      tick(); mid();
      chk($sformatf("t3_owner_g%0d", g), 64'(owner), 64'(exp_l));
      serve(64'(g) * 64'h1111, 1'b0); mid();
      chk($sformatf("t3_lsu_rsp_g%0d", g), 64'(lsu_rsp_valid), 64'(exp_l));
      chk($sformatf("t3_ifu_rsp_g%0d", g), 64'(ifu_rsp_valid), 64'(!exp_l));
    end
    ifu_req_valid = 1'b0; lsu_req_valid = 1'b0;
    chk("t3_ifu_data", ifu_rsp_data, 64'h5555);
    chk("t3_lsu_data", lsu_rsp_data, 64'h6666);

    // 4: memory accepts but never responds; timeout error 9 cycles after the handshake cycle.
    tick(); lsu_req_valid = 1'b1; lsu_req_addr = 32'h8000_4000; mid();
    chk("t4_lsu_ready", 64'(lsu_req_ready), 64'd1);
    tick(); lsu_req_valid = 1'b0; mid();
    chk("t4_mem_valid", 64'(mem_req_valid), 64'd1);
    for (int i = 1; i <= 8; i++) begin
      tick(); mid();
      chk($sformatf("t4_no_rsp_%0d", i), 64'(lsu_rsp_valid), 64'd0);
    end
    tick(); mid();
    chk("t4_to_valid", 64'(lsu_rsp_valid), 64'd1);
    chk("t4_to_err",   64'(lsu_rsp_err), 64'd1);
    chk("t4_to_data",  lsu_rsp_data, 64'd0);
    chk("t4_to_ifu",   64'(ifu_rsp_valid), 64'd0);
    tick(); mem_rsp_valid = 1'b1; mem_rsp_data = 64'h0BAD; mid();
    tick(); mem_rsp_valid = 1'b0; mem_rsp_data = '0; mid();
    chk("t4_stray_lsu", 64'(lsu_rsp_valid), 64'd0);
    chk("t4_stray_ifu", 64'(ifu_rsp_valid), 64'd0);
    chk("t4_stray_data", lsu_rsp_data, 64'd0);
    chk("t4_stray_mem", 64'(mem_req_valid), 64'd0);

    // 5: mem_req_ready low for 10 cycles in ISSUE; fields stable, no timeout, no readys.
    mem_req_ready = 1'b0;
    tick();
    lsu_req_valid = 1'b1; lsu_req_addr = 32'h8000_5000; lsu_req_wen = 1'b1;
    lsu_req_wdata = 64'hCAFE_F00D_DEAD_BEEF; lsu_req_wmask = 8'h0F;
    mid();
    chk("t5_lsu_ready", 64'(lsu_req_ready), 64'd1);
    tick();
    lsu_req_addr = 32'h8000_6000; lsu_req_wdata = '0; ifu_req_valid = 1'b1;
    for (int i = 1; i <= 10; i++) begin
      mid();
      chk($sformatf("t5_valid_%0d", i), 64'(mem_req_valid), 64'd1);
      chk($sformatf("t5_addr_%0d", i),  64'(mem_req_addr), 64'h8000_5000);
      chk($sformatf("t5_wdata_%0d", i), mem_req_wdata, 64'hCAFE_F00D_DEAD_BEEF);
      chk($sformatf("t5_ifu_rdy_%0d", i), 64'(ifu_req_ready), 64'd0);
      chk($sformatf("t5_lsu_rdy_%0d", i), 64'(lsu_req_ready), 64'd0);
      chk($sformatf("t5_rsp_%0d", i), 64'(lsu_rsp_valid), 64'd0);
      tick();
    end
    ifu_req_valid = 1'b0; lsu_req_valid = 1'b0; mem_req_ready = 1'b1; mid();
    chk("t5_still_issue", 64'(mem_req_valid), 64'd1);
    serve(64'h77, 1'b0); mid();
    chk("t5_rsp_valid", 64'(lsu_rsp_valid), 64'd1);
    chk("t5_rsp_err",   64'(lsu_rsp_err), 64'd0);

    // 6: asynchronous reset mid-WAIT, late response ignored, then normal IFU fetch.
    tick(); ifu_req_valid = 1'b1; ifu_req_addr = 32'h8000_7000; mid();
    chk("t6_ifu_ready", 64'(ifu_req_ready), 64'd1);
    tick(); ifu_req_valid = 1'b0; mid();
    chk("t6_mem_valid", 64'(mem_req_valid), 64'd1);
    tick();
    rst = 1'b1; ifu_req_valid = 1'b1; #1;
    chk("t6_rst_mem_valid", 64'(mem_req_valid), 64'd0);
    chk("t6_rst_addr",      64'(mem_req_addr), 64'd0);
    chk("t6_rst_lsu_data",  lsu_rsp_data, 64'd0);
    chk("t6_rst_ifu_data",  ifu_rsp_data, 64'd0);
    chk("t6_rst_ifu_ready", 64'(ifu_req_ready), 64'd0);
    ifu_req_valid = 1'b0; mem_rsp_valid = 1'b1; mem_rsp_data = 64'hFEED;
    tick(); rst = 1'b0; mid();
    chk("t6_late_ifu_a", 64'(ifu_rsp_valid), 64'd0);
    tick(); mem_rsp_valid = 1'b0; mem_rsp_data = '0; mid();
    chk("t6_late_ifu_b", 64'(ifu_rsp_valid), 64'd0);
    chk("t6_late_data",  ifu_rsp_data, 64'd0);
    chk("t6_idle_mem",   64'(mem_req_valid), 64'd0);
    tick(); ifu_req_valid = 1'b1; ifu_req_addr = 32'h8000_8000; mid();
    chk("t6_new_ready", 64'(ifu_req_ready), 64'd1);
    tick(); ifu_req_valid = 1'b0; mid();
    chk("t6_new_addr", 64'(mem_req_addr), 64'h8000_8000);
    serve(64'hABCD, 1'b0); mid();
    chk("t6_new_rsp_valid", 64'(ifu_rsp_valid), 64'd1);
    chk("t6_new_rsp_data",  ifu_rsp_data, 64'hABCD);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
